// File: rtl/bcd_step_counter.sv
// Two-digit BCD step counter with debounced button / prescaler step source and two-digit display scan.
// Latency: button to count 2 + DEBOUNCE_CYCLES cycles; count to W..Z one further cycle.
// Backpressure: none; free-running, every step is taken on the edge it occurs.
module bcd_step_counter #(
  parameter int PRESCALE        = 12000000,
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int SCAN_DIV        = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       up_dn,
  input  logic       run,
  input  logic       clr,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic [1:0] dig_sel,
  output logic       wrap
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);

  typedef enum logic {REL, PRS} db_state_t;

  logic            sync_1, sync_2;
  db_state_t       db_state_q, db_state_d;
  logic [DW-1:0]   db_cnt_q, db_cnt_d;
  logic            step_btn;
  logic [PW-1:0]   presc_q;
  logic            tick;
  logic            step;
  logic [3:0]      ones_q, tens_q, ones_d, tens_d;
  logic            wrap_d;
  logic [SW-1:0]   scan_q;
  logic [1:0]      dig_sel_q, dig_sel_d;
  logic [3:0]      nib_q;
  logic            wrap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn_step;
      sync_2 <= sync_1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_state_q <= REL;
      db_cnt_q   <= '0;
    end else begin
      db_state_q <= db_state_d;
      db_cnt_q   <= db_cnt_d;
    end
  end

  // Count consecutive samples at the opposite level; only the press edge emits a step.
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = db_cnt_q;
    step_btn   = 1'b0;
    case (db_state_q)
      REL: begin
        if (sync_2) begin
          if (db_cnt_q == DB_LAST) begin
            db_state_d = PRS;
            db_cnt_d   = '0;
            step_btn   = 1'b1;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
        end
      end
      PRS: begin
        if (!sync_2) begin
          if (db_cnt_q == DB_LAST) begin
            db_state_d = REL;
            db_cnt_d   = '0;
          end else begin
            db_cnt_d = db_cnt_q + 1'b1;
          end
        end else begin
          db_cnt_d = '0;
        end
      end
      default: begin
        db_state_d = REL;
        db_cnt_d   = '0;
      end
    endcase
  end

  assign tick = run && (presc_q == PRESC_LAST);
  assign step = run ? tick : step_btn;

  always_ff @(posedge clk) begin
    if (rst || !run || tick) presc_q <= '0;
    else                     presc_q <= presc_q + 1'b1;
  end

  always_comb begin
    ones_d = ones_q;
    tens_d = tens_q;
    wrap_d = 1'b0;
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (step) begin
      if (up_dn) begin
        if (ones_q >= 4'd9) begin
          ones_d = 4'd0;
          if (tens_q >= 4'd9) begin
            tens_d = 4'd0;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q + 4'd1;
          end
        end else begin
          ones_d = ones_q + 4'd1;
        end
      end else begin
        if (ones_q == 4'd0) begin
          ones_d = 4'd9;
          if (tens_q == 4'd0) begin
            tens_d = 4'd9;
            wrap_d = 1'b1;
          end else begin
            tens_d = tens_q - 4'd1;
          end
        end else begin
          ones_d = ones_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_q <= 4'd0;
      tens_q <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      ones_q <= ones_d;
      tens_q <= tens_d;
      wrap_q <= wrap_d;
    end
  end

  assign dig_sel_d = (scan_q == SCAN_LAST) ? {dig_sel_q[0], dig_sel_q[1]} : dig_sel_q;

  // Nibble follows the upcoming strobe so both change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q    <= '0;
      dig_sel_q <= 2'b01;
      nib_q     <= 4'd0;
    end else begin
      scan_q    <= (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
      dig_sel_q <= dig_sel_d;
      nib_q     <= dig_sel_d[0] ? ones_q : tens_q;
    end
  end

  assign W       = nib_q[0];
  assign X       = nib_q[1];
  assign Y       = nib_q[2];
  assign Z       = nib_q[3];
  assign dig_sel = dig_sel_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Scoreboard bench for bcd_step_counter: model counts pushed to a queue, popped when the display is read.
module tb_bcd_step_counter;

  localparam int PRESCALE = 10;
  localparam int DEB      = 4;
  localparam int SCAN     = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_step = 1'b1;
  logic       up_dn = 1'b1;
  logic       run = 1'b1;
  logic       clr = 1'b0;
  logic       W, X, Y, Z;
  logic [1:0] dig_sel;
  logic       wrap;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  int exp_q[$];

  bcd_step_counter #(.PRESCALE(PRESCALE), .DEBOUNCE_CYCLES(DEB), .SCAN_DIV(SCAN)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .up_dn(up_dn), .run(run), .clr(clr),
    .W(W), .X(X), .Y(Y), .Z(Z), .dig_sel(dig_sel), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Pop the next expected count and compare it against both displayed digits.
  task automatic read_count();
    int exp_v;
    int ok;
    logic [3:0] nib;
    exp_v = exp_q.pop_front();
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      ok = 0;
      for (int i = 0; i < 4 * SCAN && ok == 0; i++) begin
        if (dig_sel === ((d == 0) ? 2'b01 : 2'b10)) ok = 1;
        else @(negedge clk);
      end
      nib = {Z, Y, X, W};
      checks++;
      if (ok == 0) begin
        failures++;
        $display("FAIL digit_phase%0d: dig_sel=%b never reached required phase", d, dig_sel);
      end else if (nib !== 4'((d == 0) ? exp_v % 10 : exp_v / 10)) begin
        failures++;
        $display("FAIL digit%0d: got %0d required %0d (count %0d)", d, nib,
                 (d == 0) ? exp_v % 10 : exp_v / 10, exp_v);
      end
      checks++;
      if (nib > 4'd9) begin
        failures++;
        $display("FAIL bcd_range%0d: got %0d required <=9", d, nib);
      end
    end
  endtask

  task automatic run_ticks(input int n, input logic dir);
    logic exp_wrap;
    up_dn = dir;
    run = 1'b1;
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      if (t > 0) begin
        checks++;
        if (wrap !== 1'b0) begin
          failures++;
          $display("FAIL wrap_width: got %b required 0", wrap);
        end
      end
      repeat (PRESCALE - 1) @(negedge clk);
      exp_wrap = 1'b0;
      if (dir) begin
        if (m_cnt == 99) begin m_cnt = 0; exp_wrap = 1'b1; end
        else m_cnt++;
      end else begin
        if (m_cnt == 0) begin m_cnt = 99; exp_wrap = 1'b1; end
        else m_cnt--;
      end
      checks++;
      if (wrap !== exp_wrap) begin
        failures++;
        $display("FAIL wrap_tick: got %b required %b (count %0d)", wrap, exp_wrap, m_cnt);
      end
    end
    run = 1'b0;
    @(negedge clk);
    checks++;
    if (wrap !== 1'b0) begin
      failures++;
      $display("FAIL wrap_after: got %b required 0", wrap);
    end
    exp_q.push_back(m_cnt);
  endtask

  task automatic test_reset();
    logic [1:0] exp_sel;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({Z, Y, X, W} !== 4'd0 || dig_sel !== 2'b01 || wrap !== 1'b0) begin
        failures++;
        $display("FAIL reset_vals: nib=%b dig_sel=%b wrap=%b required 0000/01/0",
                 {Z, Y, X, W}, dig_sel, wrap);
      end
    end
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_sel = ((k / 3) % 2 == 1) ? 2'b10 : 2'b01;
      checks++;
      if (dig_sel !== exp_sel) begin
        failures++;
        $display("FAIL scan_toggle k=%0d: got %b required %b", k, dig_sel, exp_sel);
      end
    end
    run = 1'b0;
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    m_cnt = 0;
    exp_q.push_back(m_cnt);
    read_count();
  endtask

  task automatic test_debounce();
    up_dn = 1'b1;
    run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      btn_step = (i % 2 == 0);
      @(negedge clk);
    end
    btn_step = 1'b1;
    repeat (10) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    m_cnt = m_cnt + 1;
    exp_q.push_back(m_cnt);
    read_count();
  endtask

  task automatic test_up_wrap();
    run_ticks(3, 1'b0);
    read_count();
    run_ticks(1, 1'b1);
    read_count();
    run_ticks(1, 1'b1);
    read_count();
  endtask

  task automatic test_down_wrap();
    run_ticks(1, 1'b0);
    read_count();
    run_ticks(1, 1'b0);
    read_count();
  endtask

  task automatic test_clr_tick();
    run_ticks(47, 1'b1);
    read_count();
    up_dn = 1'b1;
    run = 1'b1;
    repeat (PRESCALE - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    run = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wrap !== 1'b0) begin
        failures++;
        $display("FAIL clr_no_wrap: got %b required 0", wrap);
      end
      @(negedge clk);
    end
    exp_q.push_back(m_cnt);
    read_count();
  endtask

  task automatic test_carry_borrow();
    run_ticks(19, 1'b1);
    read_count();
    run_ticks(1, 1'b1);
    read_count();
    run_ticks(1, 1'b0);
    read_count();
  endtask

  task automatic test_reset_mid_press();
    run = 1'b0;
    up_dn = 1'b1;
    btn_step = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (wrap !== 1'b0 || dig_sel !== 2'b01) begin
        failures++;
        $display("FAIL reset_mid: wrap=%b dig_sel=%b required 0/01", wrap, dig_sel);
      end
    end
    rst = 1'b0;
    repeat (15) @(negedge clk);
    btn_step = 1'b0;
    repeat (12) @(negedge clk);
    m_cnt = 1;
    exp_q.push_back(m_cnt);
    read_count();
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_up_wrap();
    test_down_wrap();
    test_clr_tick();
    test_carry_borrow();
    test_reset_mid_press();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_step_counter.md
Name: bcd_step_counter

Overview:
- Two-digit BCD counter (00–99) that produces the 4-bit nibble W,X,Y,Z consumed directly by the seven-segment display decoder, plus one-hot digit-select strobes for time-multiplexing two displays.
- Advances from a debounced push-button in manual mode, or from an internal prescaler tick in run mode.
- Sits between the board button/switches and the display decoder.

Parameters:
- PRESCALE, 12000000: clock cycles per auto-count tick in run mode (≥2).
- DEBOUNCE_CYCLES, 120000: consecutive stable synchronized samples required to accept a button level change (≥2).
- SCAN_DIV, 12000: clock cycles each digit is displayed before the scan moves to the other digit (≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- btn_step  input  1  raw, asynchronous, bouncing push-button; high = pressed.
- up_dn  input  1  1 = count up, 0 = count down; sampled on each step.
- run  input  1  1 = count on prescaler tick; 0 = count on button press.
- clr  input  1  synchronous clear of the count to 00.
- W  output  1  nibble bit 0 (LSB) of the selected digit.
- X  output  1  nibble bit 1.
- Y  output  1  nibble bit 2.
- Z  output  1  nibble bit 3 (MSB).
- dig_sel  output  2  one-hot, active-high; 01 = ones digit on W..Z, 10 = tens digit.
- wrap  output  1  one-cycle pulse when the count wraps (99→00 up, 00→99 down).

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs. All outputs registered. Reset values: ones=0, tens=0, W=X=Y=Z=0, dig_sel=01, wrap=0. Prescaler, scan counter, debounce counter, synchronizer flops and debounced level all cleared to 0.
- Synchronizer: btn_step passes through 2 flops before use.
- Debouncer FSM, states REL and PRS:
  - In REL: count consecutive cycles with sync=1; when the count reaches DEBOUNCE_CYCLES, go to PRS and emit step_btn for 1 cycle. Any sample with sync=0 clears the count.
  - In PRS: symmetric, counting sync=0; return to REL with no pulse.
  - Button-to-step latency: 2 (sync) + DEBOUNCE_CYCLES cycles.
- Step source:
  - run=1: step = prescaler terminal tick. Prescaler counts 0..PRESCALE-1; tick occurs when it wraps to 0. step_btn is ignored, but the debouncer keeps tracking.
  - run=0: step = step_btn. Prescaler is held at 0, so the first tick after run rises comes exactly PRESCALE cycles later.
- Count update, on the edge where step=1:
  - up: ones+1. ones=9 → ones=0 and tens+1. tens=9 and ones=9 → 00 with wrap=1 on the next cycle.
  - down: mirror behaviour. 00 → 99 with wrap=1.
  - ones and tens always stay in 0..9; codes 10–15 are never produced.
- clr and step in the same cycle: clr wins; count becomes 00, no wrap pulse. clr does not affect the prescaler, scan or debouncer.
- Scan:
  - Scan counter runs 0..SCAN_DIV-1 continuously, independent of run.
  - On its wrap, dig_sel toggles between 01 and 10.
  - Each cycle, W..Z register the digit selected by the next dig_sel value, so nibble and strobe always change on the same edge.
  - A count change reaches W..Z one cycle after the count register updates.
- wrap: registered, exactly 1 cycle wide, never asserted during or immediately after reset.
- Reset mid-press: debouncer returns to REL. A button still held after reset produces one step once it has been stable for DEBOUNCE_CYCLES.

Test Plan (PRESCALE=10, DEBOUNCE_CYCLES=4, SCAN_DIV=3):
- Reset applied with btn_step=1 and run=1 → during reset W..Z=0000, dig_sel=01, wrap=0. After release, dig_sel toggles every 3 cycles.
- run=0, up_dn=1, btn toggling 1/0/1/0 every cycle, then held 1 for 10 cycles → exactly one step: count 00→01; ones nibble W..Z=1,0,0,0 during the dig_sel=01 phase.
- run=1, up_dn=1 from 98 → after 10 cycles count=99; after 20 cycles count=00, with wrap high for exactly 1 cycle and tens nibble 0000 during the dig_sel=10 phase.
- run=1, up_dn=0 from 00 → first tick gives 99 with a wrap pulse; next tick gives 98.
- From 45, clr asserted on the same cycle as a prescaler tick → count=00, no wrap.
- From 19 up → 20 (ones carries into tens). From 20 down → 19 (borrow). Check both nibbles never exceed 1001.
